// File: rtl/bw_pkg.sv
// Shared types and default widths for the Baugh-Wooley MAC datapath.
package bw_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DONE} bw_acc_state_e;

   localparam int unsigned BW_WIDTH     = 8;
   localparam int unsigned BW_ACC_WIDTH = 20;
   localparam int unsigned BW_CNT_WIDTH = 16;

endpackage

// File: rtl/bw_sat_add.sv
// Combinational signed saturating adder: a_i + sext(b_i), clamped to p_acc_width bits.
module bw_sat_add #(
   parameter int unsigned p_acc_width = 20,
   parameter int unsigned p_in_width  = 16
) (
   input  logic [p_acc_width-1:0] a_i,
   input  logic [p_in_width-1:0]  b_i,
   output logic [p_acc_width-1:0] sum_o,
   output logic                   ovf_o
);

   localparam logic [p_acc_width-1:0] MaxPos = {1'b0, {(p_acc_width-1){1'b1}}};
   localparam logic [p_acc_width-1:0] MaxNeg = {1'b1, {(p_acc_width-1){1'b0}}};

   logic [p_acc_width:0] wide;

   // One guard bit is enough: the two top bits disagree exactly when the result is out of range.
   always_comb begin
      wide  = {a_i[p_acc_width-1], a_i}
            + {{(p_acc_width+1-p_in_width){b_i[p_in_width-1]}}, b_i};
      ovf_o = wide[p_acc_width] ^ wide[p_acc_width-1];
      if (ovf_o) begin
         sum_o = wide[p_acc_width] ? MaxNeg : MaxPos;
      end else begin
         sum_o = wide[p_acc_width-1:0];
      end
   end

endmodule

// File: rtl/bw_mac_accum.sv
// Accumulates a programmed number of signed products with saturation and returns the
// sum over a valid/ready handshake.
module bw_mac_accum
   import bw_pkg::*;
#(
   parameter int unsigned p_width     = BW_WIDTH,
   parameter int unsigned p_acc_width = BW_ACC_WIDTH,
   parameter int unsigned p_cnt_width = BW_CNT_WIDTH
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic [p_cnt_width-1:0] count_i,
   input  logic                   prod_valid_i,
   output logic                   prod_ready_o,
   input  logic [2*p_width-1:0]   product_i,
   output logic                   acc_valid_o,
   input  logic                   acc_ready_i,
   output logic [p_acc_width-1:0] acc_o,
   output logic                   ovf_o,
   output logic                   busy_o
);

   if (p_acc_width < 2*p_width) begin : g_width_check
      $error("bw_mac_accum: p_acc_width must be >= 2*p_width");
   end

   bw_acc_state_e          state_q, state_d;
   logic [p_cnt_width-1:0] remaining_q, remaining_d;
   logic [p_acc_width-1:0] acc_q, acc_d;
   logic                   ovf_q, ovf_d;

   logic [p_acc_width-1:0] sat_sum;
   logic                   sat_ovf;
   logic                   prod_hs;

   bw_sat_add #(
      .p_acc_width (p_acc_width),
      .p_in_width  (2*p_width)
   ) u_sat_add (
      .a_i   (acc_q),
      .b_i   (product_i),
      .sum_o (sat_sum),
      .ovf_o (sat_ovf)
   );

   // Outputs decoded from registered state only.
   always_comb begin
      prod_ready_o = (state_q == ST_ACCUM);
      acc_valid_o  = (state_q == ST_DONE);
      busy_o       = (state_q != ST_IDLE);
      acc_o        = acc_q;
      ovf_o        = ovf_q;
      prod_hs      = prod_valid_i & prod_ready_o;
   end

   // Next-state logic for the FSM, remaining counter and accumulator.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               acc_d       = '0;
               ovf_d       = 1'b0;
               remaining_d = count_i;
               state_d     = (count_i == '0) ? ST_DONE : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (prod_hs) begin
               acc_d       = sat_sum;
               ovf_d       = ovf_q | sat_ovf;
               remaining_d = remaining_q - p_cnt_width'(1);
               if (remaining_q == p_cnt_width'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (acc_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
      end
   end

endmodule
